// File: rtl/lsu_wb_pkg.sv
// lsu_wb_pkg: access type, cause and FSM state encodings shared by the load/store unit.
package lsu_wb_pkg;
    typedef enum logic [1:0] {
        TYPE_DOUBLE = 2'b00,
        TYPE_BYTE   = 2'b01,
        TYPE_HALF   = 2'b10,
        TYPE_WORD   = 2'b11
    } lsu_type_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_BUS      = 2'b10,
        CAUSE_TIMEOUT  = 2'b11
    } lsu_cause_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUS  = 2'b01,
        S_RESP = 2'b10
    } lsu_state_e;

    function automatic logic [7:0] size_mask(lsu_type_e t);
        return t == TYPE_BYTE ? 8'h01 : t == TYPE_HALF ? 8'h03 : t == TYPE_WORD ? 8'h0F : 8'hFF;
    endfunction
endpackage

// File: rtl/lsu_wb_if.sv
// lsu_wb_if: core-side request/response channel and Wishbone-classic data bus.
interface lsu_req_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              valid;
    logic              ready;
    logic              we;
    logic [1:0]        typ;
    logic              sign;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   dat;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_dat;
    logic              rsp_err;
    logic [1:0]        rsp_cause;
    modport master (output valid, we, typ, sign, addr, dat, input ready, rsp_valid, rsp_dat, rsp_err, rsp_cause);
    modport slave (input valid, we, typ, sign, addr, dat, output ready, rsp_valid, rsp_dat, rsp_err, rsp_cause);
endinterface

interface wb_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [XLEN/8-1:0] sel;
    logic [ADDR_W-1:0] adr;
    logic [XLEN-1:0]   wdat;
    logic [XLEN-1:0]   rdat;
    logic              ack;
    logic              err;
    modport master (output cyc, stb, we, sel, adr, wdat, input rdat, ack, err);
    modport slave (input cyc, stb, we, sel, adr, wdat, output rdat, ack, err);
endinterface

// File: rtl/lsu_wb_align.sv
// lsu_wb_align: byte-lane steering, select mask, load extension and misalignment check.
module lsu_wb_align
    import lsu_wb_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB = XLEN / 8,
    localparam int OW = $clog2(NB)
) (
    input  logic [2:0]      lo,
    input  lsu_type_e       typ,
    input  logic            sign,
    input  logic [XLEN-1:0] st_dat,
    input  logic [XLEN-1:0] rd_dat,
    output logic [NB-1:0]   sel,
    output logic [XLEN-1:0] wr_dat,
    output logic [XLEN-1:0] ld_dat,
    output logic            mis
);
    logic [OW-1:0]   off;
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] lm;
    logic            msb;
    always_comb begin
        off    = lo[OW-1:0];
        mis    = (typ == TYPE_HALF && lo[0]) || (typ == TYPE_WORD && lo[1:0] != 2'b00) ||
                 (typ == TYPE_DOUBLE && (XLEN == 32 || lo != 3'b000));
        sel    = NB'(size_mask(typ)) << off;
        wr_dat = typ == TYPE_BYTE ? {NB{st_dat[7:0]}} : typ == TYPE_HALF ? {(NB/2){st_dat[15:0]}} :
                 typ == TYPE_WORD ? {(NB/4){st_dat[31:0]}} : st_dat;
        sh     = rd_dat >> {off, 3'b000};
        // lm keeps the loaded bits; everything above it is filled with the sign bit or zero
        lm     = typ == TYPE_BYTE ? XLEN'(8'hFF) : typ == TYPE_HALF ? XLEN'(16'hFFFF) :
                 typ == TYPE_WORD ? XLEN'(32'hFFFF_FFFF) : '1;
        msb    = typ == TYPE_BYTE ? sh[7] : typ == TYPE_HALF ? sh[15] : typ == TYPE_WORD ? sh[31] : 1'b0;
        ld_dat = (sh & lm) | ({XLEN{sign & msb}} & ~lm);
    end
endmodule

// File: rtl/lsu_wb.sv
// lsu_wb: sequential load/store unit driving a Wishbone-classic data bus, one access at a time.
module lsu_wb
    import lsu_wb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255,
    localparam int NB = XLEN / 8
) (
    input logic      clk_i,
    input logic      rst_i,
    lsu_req_if.slave req,
    wb_if.master     wb
);
    lsu_state_e        state, nxt;
    lsu_cause_e        cause_q;
    lsu_type_e         typ_q, typ;
    logic              we_q, sign_q, sign;
    logic [2:0]        lo_q, lo;
    logic [ADDR_W-1:0] adr_q;
    logic [NB-1:0]     sel_q, sel;
    logic [XLEN-1:0]   wdat_q, rdat_q, wr_dat, ld_dat;
    logic [31:0]       cnt;
    logic              idle, bus, resp, accept, tmo, mis;

    // In IDLE the aligner looks at the incoming request; afterwards at the latched one.
    always_comb begin
        idle   = state == S_IDLE;
        bus    = state == S_BUS;
        resp   = state == S_RESP;
        accept = idle && req.valid;
        lo     = idle ? req.addr[2:0] : lo_q;
        typ    = idle ? lsu_type_e'(req.typ) : typ_q;
        sign   = idle ? req.sign : sign_q;
        tmo    = bus && TIMEOUT != 0 && cnt == 32'(TIMEOUT - 1);
        nxt    = idle ? (req.valid ? (mis ? S_RESP : S_BUS) : S_IDLE) :
                 bus ? ((wb.ack || wb.err || tmo) ? S_RESP : S_BUS) : S_IDLE;
    end

    lsu_wb_align #(.XLEN(XLEN)) u_align (
        .lo    (lo),
        .typ   (typ),
        .sign  (sign),
        .st_dat(req.dat),
        .rd_dat(wb.rdat),
        .sel   (sel),
        .wr_dat(wr_dat),
        .ld_dat(ld_dat),
        .mis   (mis)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            cause_q <= CAUSE_NONE;
            typ_q   <= TYPE_WORD;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            lo_q    <= '0;
            adr_q   <= '0;
            sel_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            cnt     <= '0;
        end else begin
            state <= nxt;
            if (accept) begin
                we_q    <= req.we;
                typ_q   <= lsu_type_e'(req.typ);
                sign_q  <= req.sign;
                lo_q    <= req.addr[2:0];
                adr_q   <= req.addr & ~ADDR_W'(NB - 1);
                sel_q   <= sel;
                wdat_q  <= wr_dat;
                rdat_q  <= '0;
                cnt     <= '0;
                cause_q <= mis ? CAUSE_MISALIGN : CAUSE_NONE;
            end
            if (bus) begin
                cnt     <= cnt + 32'd1;
                cause_q <= wb.err ? CAUSE_BUS : wb.ack ? CAUSE_NONE : tmo ? CAUSE_TIMEOUT : cause_q;
                if (wb.ack && !wb.err && !we_q) rdat_q <= ld_dat;
            end
        end
    end

    assign req.ready     = idle && !rst_i;
    assign req.rsp_valid = resp;
    assign req.rsp_dat   = resp ? rdat_q : '0;
    assign req.rsp_err   = resp && cause_q != CAUSE_NONE;
    assign req.rsp_cause = resp ? cause_q : CAUSE_NONE;
    assign wb.cyc        = bus;
    assign wb.stb        = bus;
    assign wb.we         = bus && we_q;
    assign wb.sel        = bus ? sel_q : '0;
    assign wb.adr        = bus ? adr_q : '0;
    assign wb.wdat       = bus ? wdat_q : '0;
endmodule

// File: tb/tb_lsu_wb.sv
// tb_lsu_wb: scoreboard bench for lsu_wb at XLEN=32 (short timeout) and XLEN=64.
module tb_lsu_wb;
    typedef struct packed {
        logic [63:0] dat;
        logic [1:0]  cause;
    } exp_t;

    logic clk = 1'b0;
    logic rst32 = 1'b1;
    logic rst64 = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   mode_g = 0;
    int   wait_g = 0;
    logic [63:0] rdat_g = '0;
    int   bc32 = 0;
    int   bc64 = 0;
    int   idx32 = 0;
    int   idx64 = 0;
    exp_t sb32[$];
    exp_t sb64[$];

    always #5 clk = ~clk;

    lsu_req_if #(.XLEN(32), .ADDR_W(32)) r32();
    wb_if      #(.XLEN(32), .ADDR_W(32)) w32();
    lsu_req_if #(.XLEN(64), .ADDR_W(32)) r64();
    wb_if      #(.XLEN(64), .ADDR_W(32)) w64();

    lsu_wb #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) d32 (.clk_i(clk), .rst_i(rst32), .req(r32), .wb(w32));
    lsu_wb #(.XLEN(64), .ADDR_W(32)) d64 (.clk_i(clk), .rst_i(rst64), .req(r64), .wb(w64));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bus slave: mode 0 ack, 1 err, 2 ack+err, 3 silent; answers after wait_g wait states.
    always @(negedge clk) begin
        w32.ack = 1'b0;
        w32.err = 1'b0;
        w64.ack = 1'b0;
        w64.err = 1'b0;
        w32.rdat = rdat_g[31:0];
        w64.rdat = rdat_g;
        if (w32.cyc) begin
            if (bc32 == wait_g) begin
                w32.ack = mode_g == 0 || mode_g == 2;
                w32.err = mode_g == 1 || mode_g == 2;
            end
            bc32++;
        end else bc32 = 0;
        if (w64.cyc) begin
            if (bc64 == wait_g) begin
                w64.ack = mode_g == 0 || mode_g == 2;
                w64.err = mode_g == 1 || mode_g == 2;
            end
            bc64++;
        end else bc64 = 0;
    end

    always @(negedge clk) begin : mon32
        exp_t e;
        if (r32.rsp_valid) begin
            if (sb32.size() == 0) check("rsp32_unexpected", 64'd1, 64'd0);
            else begin
                e = sb32.pop_front();
                check($sformatf("rsp32_%0d_dat", idx32), 64'(r32.rsp_dat), e.dat);
                check($sformatf("rsp32_%0d_cause", idx32), 64'(r32.rsp_cause), 64'(e.cause));
                check($sformatf("rsp32_%0d_err", idx32), 64'(r32.rsp_err), 64'(e.cause != 2'b00));
                idx32++;
            end
        end
    end

    always @(negedge clk) begin : mon64
        exp_t e;
        if (r64.rsp_valid) begin
            if (sb64.size() == 0) check("rsp64_unexpected", 64'd1, 64'd0);
            else begin
                e = sb64.pop_front();
                check($sformatf("rsp64_%0d_dat", idx64), r64.rsp_dat, e.dat);
                check($sformatf("rsp64_%0d_cause", idx64), 64'(r64.rsp_cause), 64'(e.cause));
                check($sformatf("rsp64_%0d_err", idx64), 64'(r64.rsp_err), 64'(e.cause != 2'b00));
                idx64++;
            end
        end
    end

    task automatic run(input bit big, input bit we, input logic [1:0] t, input bit s, input logic [31:0] a,
                       input logic [63:0] d, input int mode, input int wt, input logic [63:0] rd,
                       input logic [63:0] e_dat, input logic [1:0] e_cause, input int e_lat, input int e_ncyc,
                       input logic [7:0] e_sel, input logic [63:0] e_wdat, input logic [31:0] e_adr);
        string       tag;
        int          lat, ncyc;
        bit          rv, cyc, unstable;
        logic [7:0]  sel_now, sel_c;
        logic [63:0] wdat_now, wdat_c;
        logic [31:0] adr_now, adr_c;
        logic        we_now, we_c;
        tag = $sformatf("%s_%h", big ? "x64" : "x32", a);
        mode_g = mode;
        wait_g = wt;
        rdat_g = rd;
        @(negedge clk);
        if (big) begin
            sb64.push_back({e_dat, e_cause});
            r64.we = we; r64.typ = t; r64.sign = s; r64.addr = a; r64.dat = d; r64.valid = 1'b1;
        end else begin
            sb32.push_back({e_dat, e_cause});
            r32.we = we; r32.typ = t; r32.sign = s; r32.addr = a; r32.dat = d[31:0]; r32.valid = 1'b1;
        end
        lat = 0; ncyc = 0; unstable = 1'b0; rv = 1'b0;
        sel_c = '0; wdat_c = '0; adr_c = '0; we_c = 1'b0;
        while (!rv && lat < 50) begin
            @(negedge clk);
            lat++;
            r32.valid = 1'b0;
            r64.valid = 1'b0;
            cyc      = big ? w64.cyc : w32.cyc;
            sel_now  = big ? w64.sel : 8'(w32.sel);
            wdat_now = big ? w64.wdat : 64'(w32.wdat);
            adr_now  = big ? w64.adr : w32.adr;
            we_now   = big ? w64.we : w32.we;
            rv       = big ? r64.rsp_valid : r32.rsp_valid;
            if (cyc) begin
                if (ncyc == 0) begin
                    sel_c = sel_now; wdat_c = wdat_now; adr_c = adr_now; we_c = we_now;
                end else if (sel_now != sel_c || wdat_now != wdat_c || adr_now != adr_c || we_now != we_c)
                    unstable = 1'b1;
                ncyc++;
            end
            if (!rv)
                check({tag, "_quiet"}, big ? 64'({r64.rsp_err, r64.rsp_cause, |r64.rsp_dat}) :
                                             64'({r32.rsp_err, r32.rsp_cause, |r32.rsp_dat}), 64'd0);
        end
        check({tag, "_lat"}, 64'(lat), 64'(e_lat));
        check({tag, "_ncyc"}, 64'(ncyc), 64'(e_ncyc));
        if (e_ncyc != 0) begin
            check({tag, "_sel"}, 64'(sel_c), 64'(e_sel));
            check({tag, "_wdat"}, wdat_c, e_wdat);
            check({tag, "_adr"}, 64'(adr_c), 64'(e_adr));
            check({tag, "_we"}, 64'(we_c), 64'(we));
            check({tag, "_stable"}, 64'(unstable), 64'd0);
        end
    endtask

    initial begin
        r32.valid = 1'b0; r32.we = 1'b0; r32.typ = 2'b00; r32.sign = 1'b0; r32.addr = '0; r32.dat = '0;
        r64.valid = 1'b0; r64.we = 1'b0; r64.typ = 2'b00; r64.sign = 1'b0; r64.addr = '0; r64.dat = '0;
        repeat (3) @(negedge clk);
        check("reset_ready32", 64'(r32.ready), 64'd0);
        check("reset_cyc32", 64'(w32.cyc), 64'd0);
        check("reset_rsp64", 64'(r64.rsp_valid), 64'd0);
        rst32 = 1'b0;
        rst64 = 1'b0;
        @(negedge clk);
        check("ready32_after_reset", 64'(r32.ready), 64'd1);
        check("ready64_after_reset", 64'(r64.ready), 64'd1);
        //  big we  t      s     addr          data                 md wt rdat                     e_dat                    ca     lat cyc sel    wdat                     adr
        run(0, 1, 2'b01, 0, 32'h1003, 64'hAB,                0, 2, 64'h0,                 64'h0,                   2'b00, 4, 3, 8'h08, 64'hABAB_ABAB,           32'h1000);
        run(0, 0, 2'b10, 1, 32'h2002, 64'h0,                 0, 0, 64'h8001_1234,         64'hFFFF_8001,           2'b00, 2, 1, 8'h0C, 64'h0,                   32'h2000);
        run(0, 0, 2'b10, 0, 32'h2002, 64'h0,                 0, 0, 64'h8001_1234,         64'h0000_8001,           2'b00, 2, 1, 8'h0C, 64'h0,                   32'h2000);
        run(0, 0, 2'b00, 0, 32'h3000, 64'h0,                 0, 0, 64'h0,                 64'h0,                   2'b01, 1, 0, 8'h00, 64'h0,                   32'h0);
        run(0, 0, 2'b11, 0, 32'h2001, 64'h0,                 0, 0, 64'h0,                 64'h0,                   2'b01, 1, 0, 8'h00, 64'h0,                   32'h0);
        run(0, 0, 2'b11, 0, 32'h5000, 64'h0,                 3, 0, 64'h0,                 64'h0,                   2'b11, 5, 4, 8'h0F, 64'h0,                   32'h5000);
        run(0, 0, 2'b11, 0, 32'h5004, 64'h0,                 2, 0, 64'hFFFF_FFFF,         64'h0,                   2'b10, 2, 1, 8'h0F, 64'h0,                   32'h5004);
        run(0, 1, 2'b11, 0, 32'h0010, 64'h1234_5678,         1, 1, 64'h0,                 64'h0,                   2'b10, 3, 2, 8'h0F, 64'h1234_5678,           32'h0010);
        run(0, 0, 2'b01, 0, 32'h1001, 64'h0,                 0, 0, 64'h9C00,              64'h9C,                  2'b00, 2, 1, 8'h02, 64'h0,                   32'h1000);
        run(0, 0, 2'b01, 1, 32'h1001, 64'h0,                 0, 0, 64'h9C00,              64'hFFFF_FF9C,           2'b00, 2, 1, 8'h02, 64'h0,                   32'h1000);
        run(0, 1, 2'b10, 0, 32'h0022, 64'hBEEF,              0, 1, 64'h0,                 64'h0,                   2'b00, 3, 2, 8'h0C, 64'hBEEF_BEEF,           32'h0020);
        run(1, 0, 2'b00, 0, 32'h3004, 64'h0,                 0, 0, 64'h0,                 64'h0,                   2'b01, 1, 0, 8'h00, 64'h0,                   32'h0);
        run(1, 0, 2'b01, 1, 32'h4005, 64'h0,                 0, 0, 64'h0000_F000_0000_0000, 64'hFFFF_FFFF_FFFF_FFF0, 2'b00, 2, 1, 8'h20, 64'h0,                 32'h4000);
        run(1, 1, 2'b00, 0, 32'h3008, 64'h1122_3344_5566_7788, 0, 0, 64'h0,               64'h0,                   2'b00, 2, 1, 8'hFF, 64'h1122_3344_5566_7788, 32'h3008);
        run(1, 1, 2'b10, 0, 32'h4006, 64'hBEEF,              0, 0, 64'h0,                 64'h0,                   2'b00, 2, 1, 8'hC0, 64'hBEEF_BEEF_BEEF_BEEF, 32'h4000);
        run(1, 0, 2'b11, 1, 32'h4004, 64'h0,                 0, 0, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321, 2'b00, 2, 1, 8'hF0, 64'h0,                 32'h4000);
        run(1, 0, 2'b00, 1, 32'h4000, 64'h0,                 0, 0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 2'b00, 2, 1, 8'hFF, 64'h0,                 32'h4000);
        run(1, 0, 2'b11, 0, 32'h4002, 64'h0,                 0, 0, 64'h0,                 64'h0,                   2'b01, 1, 0, 8'h00, 64'h0,                   32'h0);
        run(1, 0, 2'b10, 1, 32'h4003, 64'h0,                 0, 0, 64'h0,                 64'h0,                   2'b01, 1, 0, 8'h00, 64'h0,                   32'h0);
        // Reset in the middle of a bus wait: the access is dropped without a response.
        mode_g = 3;
        @(negedge clk);
        r32.we = 1'b0; r32.typ = 2'b11; r32.sign = 1'b0; r32.addr = 32'h6000; r32.valid = 1'b1;
        @(negedge clk);
        r32.valid = 1'b0;
        check("rst_mid_cyc_before", 64'(w32.cyc), 64'd1);
        @(negedge clk);
        rst32 = 1'b1;
        @(negedge clk);
        check("rst_mid_cyc", 64'(w32.cyc), 64'd0);
        check("rst_mid_stb", 64'(w32.stb), 64'd0);
        check("rst_mid_rsp", 64'(r32.rsp_valid), 64'd0);
        check("rst_mid_ready", 64'(r32.ready), 64'd0);
        rst32 = 1'b0;
        @(negedge clk);
        check("rst_mid_ready_after", 64'(r32.ready), 64'd1);
        check("rst_mid_rsp_after", 64'(r32.rsp_valid), 64'd0);
        run(0, 0, 2'b11, 1, 32'h7000, 64'h0,                 0, 0, 64'h8000_0000,         64'h8000_0000,           2'b00, 2, 1, 8'h0F, 64'h0,                   32'h7000);
        repeat (3) @(negedge clk);
        check("sb32_drained", 64'(sb32.size()), 64'd0);
        check("sb64_drained", 64'(sb64.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/lsu_wb.md
Name: lsu_wb

Overview:
- Sequential load/store unit between the core's memory stage and a Wishbone-classic data bus.
- Parametrised in data width (XLEN 32/64); adds doubleword access, a valid/ready request handshake, a registered response, bus-error capture and a bus timeout.
- Performs the same lane steering, byte-select generation, sign/zero extension and misalignment detection as the combinational LSU.
- Holds one outstanding access at a time.

Parameters:
XLEN, 32, data width; 32 or 64. Bus lane count NB = XLEN/8.
ADDR_W, 32, address width.
TIMEOUT, 255, cycles to wait for ack/err before aborting; 0 disables the timeout.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
req_valid_i  in  1  access request
req_ready_o  out  1  LSU accepts a request this cycle
req_we_i  in  1  1 = store, 0 = load
req_type_i  in  2  01 byte, 10 half, 11 word, 00 double (legal only when XLEN=64)
req_sign_i  in  1  sign-extend load result
req_addr_i  in  ADDR_W  byte address
req_dat_i  in  XLEN  store data, right-aligned
rsp_valid_o  out  1  one-cycle response pulse
rsp_dat_o  out  XLEN  load result (0 for stores)
rsp_err_o  out  1  access failed
rsp_cause_o  out  2  00 none, 01 misaligned/illegal, 10 bus error, 11 timeout
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  write enable
wb_sel_o  out  NB  byte lane selects
wb_adr_o  out  ADDR_W  address, aligned to NB bytes
wb_dat_o  out  XLEN  replicated store data
wb_dat_i  in  XLEN  read data
wb_ack_i  in  1  acknowledge
wb_err_i  in  1  bus error

Behaviour:
- Reset values: all outputs 0; req_ready_o goes to 1 in the first cycle after reset deasserts. FSM state IDLE, timeout counter 0.
- FSM states: IDLE, BUS, RESP.
- IDLE: req_ready_o=1. On req_valid_i, register all request fields.
  - Misaligned (half with addr[0]; word with addr[1:0]!=0; double with addr[2:0]!=0) or illegal (double when XLEN=32) -> RESP, cause 01. No bus activity.
  - Otherwise -> BUS.
- BUS: wb_cyc_o=wb_stb_o=1 and all wb_* outputs stable until termination; req_ready_o=0.
  - Lane offset = addr mod NB.
  - wb_sel_o = size mask shifted left by the lane offset (byte 1, half 3, word F, double FF).
  - wb_dat_o = store data replicated across all lanes.
  - wb_adr_o = addr with its low log2(NB) bits cleared.
- Termination:
  - ack -> RESP. For loads, select the lane of wb_dat_i, then sign- or zero-extend to XLEN.
  - err -> RESP, cause 10. err wins if ack and err are asserted together.
  - Counter reaches TIMEOUT -> RESP, cause 11. cyc/stb drop in the same cycle.
- RESP: rsp_valid_o=1 for exactly one cycle, with rsp_dat_o, rsp_err_o and rsp_cause_o valid; then -> IDLE. Response outputs are 0 whenever rsp_valid_o=0.
- Latency:
  - Zero-wait-state bus (ack in the first BUS cycle): accept at cycle N, ack at N+1, rsp_valid_o at N+2.
  - Misaligned access: rsp_valid_o at N+1.
- Back-to-back throughput: one access per 3 cycles minimum.
- A request presented while req_ready_o=0 is ignored; the core must hold it.
- ack/err arriving in IDLE or RESP are ignored.
- Reset asserted mid-access: cyc/stb drop in the next cycle and no response is produced.

Decomposition:
- Shared package: type encodings (TYPE_BYTE/HALF/WORD/DOUBLE), cause codes, FSM state encoding.
- One sub-module, lsu_wb_align: purely combinational. Computes the sel mask, store replication, load lane extraction and sign extension, and the misalignment flag. Reused by a future instruction-side fetch unit.

Test Plan:
- XLEN=32, store byte addr 0x1003, data 0xAB, ack after 2 waits -> wb_sel_o=1000, wb_dat_o=0xABABABAB, wb_adr_o=0x1000, rsp_valid_o 4 cycles after accept, err 0.
- XLEN=32, signed half load addr 0x2002, wb_dat_i=0x8001_1234 -> rsp_dat_o=0xFFFF8001. Repeat unsigned -> 0x00008001.
- XLEN=64, double load addr 0x3004 -> no wb_cyc_o, rsp 1 cycle after accept, rsp_cause_o=01. XLEN=32 with type 00 at 0x3000 -> same result.
- XLEN=64, byte load addr 0x4005, wb_dat_i=0x00_00_F0_00_00_00_00_00 (lane 5 = 0xF0), signed -> rsp_dat_o=0xFFFF_FFFF_FFFF_FFF0, wb_sel_o=0010_0000.
- TIMEOUT=4, no ack -> cyc drops after 4 BUS cycles, rsp_cause_o=11. Separately, ack and err asserted together -> cause 10.
- rst_i asserted during BUS wait -> cyc/stb 0 next cycle, no rsp_valid_o, req_ready_o=1 after reset deasserts.
